uart_boot_loader: RTL and testbench
===================================

# uart_boot_loader

Boot sequencer for the single-cycle RISC-V core. It holds the CPU in reset and receives a framed program image as a byte stream from the UART receiver. It assembles the bytes into 32-bit little-endian words, writes them into instruction memory and checks a checksum. It releases the CPU only after a complete, valid frame. It sits between the UART RX byte interface, the instruction-memory write port and the CPU's `reset` input.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width. DEPTH = 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYC`, 100000: maximum idle cycles between bytes inside a frame.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `reload`  in  1  request to re-enter load mode; honoured only in RUN.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  write data.
- `cpu_reset`  out  1  drives the CPU `reset`; 1 = CPU held.
- `busy`  out  1  high in every state except RUN.
- `err`  out  1  sticky frame-error flag.
- `words_loaded`  out  16  words written in the current or last frame.

## Operation
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN×4 data bytes, then CSUM.
  - LEN is the 16-bit word count.
  - CSUM is the 8-bit sum, mod 256, of the data bytes only.
- Data byte order: the first byte of each word goes to `imem_wdata[7:0]` and the fourth to `[31:24]`.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN. Reset enters IDLE.
- IDLE:
  - A byte equal to SYNC_BYTE moves to LEN_LO, clears `err`, `words_loaded`, the byte counter, the word address and the checksum.
  - Other bytes are ignored.
- LEN_LO → LEN_HI on the next byte.
- LEN_HI on the next byte:
  - LEN > DEPTH: `err`=1, go to IDLE, no writes.
  - LEN = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - Each byte is shifted into the word assembler and added to the checksum.
  - On the 4th byte of a word, the word is written: `imem_we`=1, `imem_addr`=current address. The address then increments and `words_loaded` increments.
  - After word LEN-1 is written, go to CSUM.
- CSUM, on the next byte:
  - Byte matches the checksum: go to RUN.
  - Mismatch: `err`=1, go to IDLE, `cpu_reset` stays 1.
  - Written words are not rolled back.
- RUN:
  - `cpu_reset`=0, `busy`=0.
  - `rx_valid` is ignored.
  - `reload`=1 moves to IDLE with `cpu_reset`=1.
- Timeout, in LEN_LO/LEN_HI/DATA/CSUM:
  - A cycle counter clears on every `rx_valid` and on entry to LEN_LO.
  - If it reaches TIMEOUT_CYC: `err`=1, go to IDLE.
  - A partially assembled word is discarded and not written.
- `reload` outside RUN is ignored. `rx_valid` and `reload` on the same cycle in RUN: `reload` wins and the byte is dropped.
- Address never wraps, because LEN ≤ DEPTH is enforced.

## Timing
- Reset values:
  - `cpu_reset`=1, `busy`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `err`=0, `words_loaded`=0.
  - State IDLE.
- All outputs are registered.
- Word write: the 4th byte of a word is accepted at cycle N (`rx_valid`=1). `imem_we`, `imem_addr` and `imem_wdata` are valid at N+1 for exactly one cycle. `words_loaded` updates at N+1.
- Release: a matching CSUM byte is accepted at cycle N. `cpu_reset` falls and `busy` falls at N+1.
- Reload: `reload` is sampled high at cycle N in RUN. `cpu_reset`=1 and `busy`=1 at N+1.
- Error: `err` rises the cycle after the faulting byte, or the cycle after timeout expiry. It holds until the next SYNC_BYTE is accepted or `reset`.
- Back-to-back bytes (`rx_valid` on consecutive cycles) are accepted with no loss. The write of the last word and acceptance of the CSUM byte in the following cycle do not conflict.
- `reset` asserted mid-frame: all outputs take their reset values the next cycle and the frame is abandoned.

## Test plan
- Good frame: A5 02 00 13 00 00 00 93 00 10 00 B6 → two writes: addr 0 = 0x00000013, addr 1 = 0x00100093. Each `imem_we` is one cycle, one cycle after the 4th byte. `cpu_reset` falls the cycle after B6. `err`=0, `words_loaded`=2.
- Bad checksum: same frame with CSUM 00 → both words written, `err`=1, `cpu_reset`=1, state IDLE. A following good frame clears `err` at its A5 and releases the CPU.
- Boundaries:
  - LEN=0 (A5 00 00 00) → no writes, RUN.
  - ADDR_W=10 with LEN=0x0401 (A5 01 04) → `err`=1 after the 04, no writes.
  - LEN=1024 → last write at addr 0x3FF.
- Timeout: bench TIMEOUT_CYC=16; send A5 01 00 then 3 data bytes, then silence → `err`=1 at 16 idle cycles. No `imem_we` occurs, and the state returns to IDLE.
- Noise and reload:
  - Bytes 00 FF 5A in IDLE → ignored.
  - In RUN, `rx_valid` with A5 → ignored.
  - `reload` pulse → `cpu_reset`=1 next cycle.
  - `reload`+`rx_valid` together → `reload` wins.
- Reset mid-DATA: assert `reset` after 6 data bytes → next cycle all outputs at reset values. A subsequent complete frame loads from addr 0.

Source files
------------

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: holds the CPU in reset while a framed program image
// arrives over the UART. Bytes are packed little-endian into 32-bit words and
// written to instruction memory. The CPU is released only after the frame's
// checksum matches.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for SYNC_BYTE, CPU held
// S_LEN_LO | expecting low byte of word count
// S_LEN_HI | expecting high byte of word count, range-checked here
// S_DATA   | assembling and writing words
// S_CSUM   | expecting checksum of all data bytes
// S_RUN    | CPU released, only reload is honoured
module uart_boot_loader #(
   parameter int          ADDR_W      = 10,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int          TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              err,
   output logic [15:0]       words_loaded
);

   localparam int          TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_RUN
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       len_lo;
   logic [15:0]      len;
   logic [15:0]      len_full;
   logic [1:0]       byte_cnt;
   logic [31:0]      word_sr;
   logic [7:0]       csum;
   logic [TMR_W-1:0] tmr;
   logic             in_frame;
   logic             tmr_expire;
   logic             frame_start;
   logic             wr_word;
   logic             set_err;

   assign in_frame   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);
   // Timer counts down from TIMEOUT_CYC; terminal count 1 means this idle
   // cycle is the TIMEOUT_CYC-th since the last byte.
   assign tmr_expire = in_frame && !rx_valid && (tmr == TMR_W'(1));
   assign len_full   = {rx_data, len_lo};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      wr_word     = 1'b0;
      set_err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_nxt   = S_LEN_LO;
               frame_start = 1'b1;
            end
         end
         S_LEN_LO: begin
            if (rx_valid) begin
               state_nxt = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               if ({1'b0, len_full} > DEPTH) begin
                  state_nxt = S_IDLE;
                  set_err   = 1'b1;
               end else if (len_full == 16'd0) begin
                  state_nxt = S_CSUM;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_valid && (byte_cnt == 2'd3)) begin
               wr_word = 1'b1;
               if ((words_loaded + 16'd1) == len) begin
                  state_nxt = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum) begin
                  state_nxt = S_RUN;
               end else begin
                  state_nxt = S_IDLE;
                  set_err   = 1'b1;
               end
            end
         end
         S_RUN: begin
            // reload takes priority; any byte on the same cycle is dropped.
            if (reload) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (tmr_expire) begin
         state_nxt = S_IDLE;
         set_err   = 1'b1;
      end
   end

   // Frame datapath: length capture, word assembly, checksum, timer, outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         len_lo       <= '0;
         len          <= '0;
         byte_cnt     <= '0;
         word_sr      <= '0;
         csum         <= '0;
         tmr          <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_reset    <= 1'b1;
         busy         <= 1'b1;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         imem_we   <= wr_word;
         cpu_reset <= (state_nxt != S_RUN);
         busy      <= (state_nxt != S_RUN);

         if (wr_word) begin
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= {rx_data, word_sr[31:8]};
            words_loaded <= words_loaded + 16'd1;
         end

         if (frame_start) begin
            err          <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            word_sr      <= '0;
            csum         <= '0;
         end else if (set_err) begin
            err <= 1'b1;
         end

         if (frame_start || (in_frame && rx_valid)) begin
            tmr <= TMR_W'(TIMEOUT_CYC);
         end else if (in_frame) begin
            tmr <= tmr - TMR_W'(1);
         end

         if ((state == S_LEN_LO) && rx_valid) begin
            len_lo <= rx_data;
         end
         if ((state == S_LEN_HI) && rx_valid) begin
            len <= len_full;
         end

         // First byte of a word ends up in [7:0] after four right shifts.
         if ((state == S_DATA) && rx_valid) begin
            word_sr  <= {rx_data, word_sr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum + rx_data;
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: table of per-cycle byte vectors with expected
// status, plus hand sequences for timeout, mid-frame reset and a full-depth
// frame. Memory writes are checked against a queue of expected writes.
module tb_uart_boot_loader;

   localparam int ADDR_W  = 10;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              reload = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              err;
   logic [15:0]       words_loaded;

   uart_boot_loader #(
      .ADDR_W      (ADDR_W),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .reload       (reload),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_reset    (cpu_reset),
      .busy         (busy),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              v;
      logic [7:0]        d;
      logic              rl;
      logic              push;
      logic [ADDR_W-1:0] wa;
      logic [31:0]       wd;
      logic              cr;
      logic              er;
      logic [15:0]       wl;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                due;
   } wr_t;

   vec_t vt[$];
   wr_t  sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      w.due  = cyc + 1;
      sb.push_back(w);
   endtask

   task automatic check_wr();
      wr_t w;
      if (imem_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected (cycle %0d)",
                     imem_addr, imem_wdata, cyc);
         end else begin
            w = sb.pop_front();
            chk("wr_cycle", 32'(cyc), 32'(w.due));
            chk("wr_addr", 32'(imem_addr), 32'(w.addr));
            chk("wr_data", imem_wdata, w.data);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         w = sb.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_write: imem_we %b, expected write addr %h data %h (cycle %0d)",
                  imem_we, w.addr, w.data, cyc);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rl);
      reset    = r;
      rx_valid = v;
      rx_data  = d;
      reload   = rl;
      @(posedge clk);
      #1;
      cyc++;
      reset    = 1'b0;
      rx_valid = 1'b0;
      reload   = 1'b0;
      check_wr();
   endtask

   task automatic chk_status(input string p, input logic cr, input logic er, input logic [15:0] wl);
      chk($sformatf("%s_cpu_reset", p), 32'(cpu_reset), 32'(cr));
      chk($sformatf("%s_busy", p), 32'(busy), 32'(cr));
      chk($sformatf("%s_err", p), 32'(err), 32'(er));
      chk($sformatf("%s_words_loaded", p), 32'(words_loaded), 32'(wl));
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic rl, input logic push,
                      input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                      input logic cr, input logic er, input logic [15:0] wl);
      vec_t x;
      x.v = v; x.d = d; x.rl = rl; x.push = push; x.wa = wa; x.wd = wd;
      x.cr = cr; x.er = er; x.wl = wl;
      vt.push_back(x);
   endtask

   // Plain byte with expected status after it.
   task automatic b(input logic [7:0] d, input logic cr, input logic er, input logic [15:0] wl);
      add(1'b1, d, 1'b0, 1'b0, '0, 32'h0, cr, er, wl);
   endtask

   // Fourth byte of a word: a write is expected on the following cycle.
   task automatic bw(input logic [7:0] d, input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                     input logic er, input logic [15:0] wl);
      add(1'b1, d, 1'b0, 1'b1, wa, wd, 1'b1, er, wl);
   endtask

   // Two-word program frame; the last byte is the checksum.
   task automatic frame2(input logic [7:0] cs, input logic cr_end, input logic er_end);
      b(8'hA5, 1, 0, 0); b(8'h02, 1, 0, 0); b(8'h00, 1, 0, 0);
      b(8'h13, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h00, 1, 0, 0);
      bw(8'h00, 0, 32'h0000_0013, 0, 1);
      b(8'h93, 1, 0, 1); b(8'h00, 1, 0, 1); b(8'h10, 1, 0, 1);
      bw(8'h00, 1, 32'h0010_0093, 0, 2);
      b(cs, cr_end, er_end, 2);
   endtask

   task automatic send_words(input int n, input logic [31:0] seed);
      logic [7:0]  cs;
      logic [31:0] w;
      logic [7:0]  by;
      logic [15:0] n16;
      n16 = 16'(n);
      cs  = 8'h00;
      step(0, 1, 8'hA5, 0);
      step(0, 1, n16[7:0], 0);
      step(0, 1, n16[15:8], 0);
      for (int i = 0; i < n; i++) begin
         w = seed + 32'(i) * 32'h9E37_79B1;
         for (int k = 0; k < 4; k++) begin
            by = w[8*k +: 8];
            cs = cs + by;
            if (k == 3) push_wr(ADDR_W'(i), w);
            step(0, 1, by, 0);
         end
      end
      step(0, 1, cs, 0);
      chk_status($sformatf("frame%0d_end", n), 1'b0, 1'b0, n16);
   endtask

   initial begin
      // Noise in IDLE, then the reference good frame.
      b(8'h00, 1, 0, 0); b(8'hFF, 1, 0, 0); b(8'h5A, 1, 0, 0);
      frame2(8'hB6, 0, 0);
      // RUN ignores bytes, honours reload.
      b(8'hA5, 0, 0, 2);
      add(0, 8'h00, 0, 0, '0, 32'h0, 0, 0, 2);
      add(0, 8'h00, 1, 0, '0, 32'h0, 1, 0, 2);
      // Bad checksum, then a good frame clears err and releases.
      frame2(8'h00, 1, 1);
      frame2(8'hB6, 0, 0);
      // reload with a simultaneous A5: byte dropped, so the 00s stay ignored.
      add(1, 8'hA5, 1, 0, '0, 32'h0, 1, 0, 2);
      b(8'h00, 1, 0, 2); b(8'h00, 1, 0, 2); b(8'h00, 1, 0, 2);
      // LEN = 0 goes straight to checksum.
      b(8'hA5, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h00, 1, 0, 0); b(8'h00, 0, 0, 0);
      add(0, 8'h00, 1, 0, '0, 32'h0, 1, 0, 0);
      // LEN = 0x0401 exceeds depth: error after the high byte, no writes.
      b(8'hA5, 1, 0, 0); b(8'h01, 1, 0, 0); b(8'h04, 1, 1, 0);
      b(8'h13, 1, 1, 0); b(8'h00, 1, 1, 0); b(8'h00, 1, 1, 0); b(8'h00, 1, 1, 0);

      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      chk_status("reset", 1'b1, 1'b0, 16'd0);
      chk("reset_imem_we", 32'(imem_we), 32'd0);
      chk("reset_imem_addr", 32'(imem_addr), 32'd0);
      chk("reset_imem_wdata", imem_wdata, 32'd0);

      foreach (vt[i]) begin
         if (vt[i].push) push_wr(vt[i].wa, vt[i].wd);
         step(0, vt[i].v, vt[i].d, vt[i].rl);
         chk_status($sformatf("vec%0d", i), vt[i].cr, vt[i].er, vt[i].wl);
      end

      // Timeout: three data bytes of a one-word frame, then silence.
      step(0, 1, 8'hA5, 0); step(0, 1, 8'h01, 0); step(0, 1, 8'h00, 0);
      step(0, 1, 8'h11, 0); step(0, 1, 8'h22, 0); step(0, 1, 8'h33, 0);
      for (int j = 0; j < TIMEOUT - 1; j++) step(0, 0, 8'h00, 0);
      chk("timeout_err_early", 32'(err), 32'd0);
      step(0, 0, 8'h00, 0);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_cpu_reset", 32'(cpu_reset), 32'd1);
      // Back in IDLE: a fourth byte must not complete the discarded word.
      step(0, 1, 8'h44, 0);
      step(0, 0, 8'h00, 0);
      chk_status("timeout_idle", 1'b1, 1'b1, 16'd0);
      send_words(2, 32'hDEAD_BEEF);
      step(0, 0, 8'h00, 1);

      // Reset after six data bytes of a two-word frame.
      step(0, 1, 8'hA5, 0); step(0, 1, 8'h02, 0); step(0, 1, 8'h00, 0);
      step(0, 1, 8'h01, 0); step(0, 1, 8'h02, 0); step(0, 1, 8'h03, 0);
      push_wr(0, 32'h0403_0201);
      step(0, 1, 8'h04, 0);
      step(0, 1, 8'h05, 0); step(0, 1, 8'h06, 0);
      chk("pre_reset_words_loaded", 32'(words_loaded), 32'd1);
      step(1, 0, 8'h00, 0);
      chk_status("midreset", 1'b1, 1'b0, 16'd0);
      chk("midreset_imem_we", 32'(imem_we), 32'd0);
      chk("midreset_imem_addr", 32'(imem_addr), 32'd0);
      chk("midreset_imem_wdata", imem_wdata, 32'd0);
      send_words(3, 32'h1234_5678);
      step(0, 0, 8'h00, 1);

      // Full-depth frame: last write lands at 0x3FF.
      send_words(1 << ADDR_W, 32'h0BAD_F00D);
      chk("last_imem_addr", 32'(imem_addr), 32'h3FF);

      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
